// File: rtl/ring_l2_responder.sv
// ring_l2_responder: round-robin arbiter between two core refill rings that streams one
// aligned block of L2 words to the granted core, one mem read per beat.
module ring_l2_responder #(
   parameter int DATA_W      = 64,
   parameter int ADDR_W      = 64,
   parameter int BLOCK_WORDS = 8192
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c0_ring_req,
   input  logic [ADDR_W-1:0] c0_ring_addr,
   output logic              c0_ring_ready,
   output logic              c0_rsp_valid,
   input  logic              c1_ring_req,
   input  logic [ADDR_W-1:0] c1_ring_addr,
   output logic              c1_ring_ready,
   output logic              c1_rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [31:0]       rsp_index,
   output logic              rsp_last,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              mem_rd_done
);
   localparam int IW = $clog2(BLOCK_WORDS);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLOCK_WORDS * 8 - 1);

   typedef enum logic [1:0] {IDLE, ACCEPT, READ, SEND} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [1:0]        ready_q, ready_d;
   logic [1:0]        valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [31:0]       index_q, index_d;
   logic              last_q, last_d;
   logic              rd_en_q, rd_en_d;
   logic [1:0]        req;
   logic              grant;
   logic              is_last;

   always_comb begin
      req          = {c1_ring_req, c0_ring_req};
      grant        = (req == 2'b11) ? ~last_grant_q : req[1];
      is_last      = idx_q == IW'(BLOCK_WORDS - 1);
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      base_d       = base_q;
      idx_d        = idx_q;
      ready_d      = 2'b00;
      valid_d      = 2'b00;
      data_d       = data_q;
      index_d      = index_q;
      last_d       = last_q;
      rd_en_d      = rd_en_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               owner_d = grant;
               base_d  = (grant ? c1_ring_addr : c0_ring_addr) & ~OFF_MASK;
               idx_d   = '0;
               state_d = ACCEPT;
            end
         end
         ACCEPT: begin
            ready_d      = owner_q ? 2'b10 : 2'b01;
            last_grant_d = owner_q;
            rd_en_d      = 1'b1;
            state_d      = READ;
         end
         READ: begin
            if (rd_en_q && mem_rd_done) begin
               data_d  = mem_rd_data;
               rd_en_d = 1'b0;
               valid_d = owner_q ? 2'b10 : 2'b01;
               index_d = 32'(idx_q) << 3;
               last_d  = is_last;
               state_d = SEND;
            end
         end
         SEND: begin
            if (is_last) begin
               state_d = IDLE;
            end else begin
               idx_d   = idx_q + IW'(1);
               rd_en_d = 1'b1;
               state_d = READ;
            end
         end
         default: state_d = IDLE;
      endcase
      // the address is computed once per read, on the rising edge of rd_en, then held
      mem_addr_d = (rd_en_d && !rd_en_q) ? base_d + (ADDR_W'(idx_d) << 3) : mem_addr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         base_q       <= '0;
         mem_addr_q   <= '0;
         idx_q        <= '0;
         ready_q      <= 2'b00;
         valid_q      <= 2'b00;
         data_q       <= '0;
         index_q      <= '0;
         last_q       <= 1'b0;
         rd_en_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         base_q       <= base_d;
         mem_addr_q   <= mem_addr_d;
         idx_q        <= idx_d;
         ready_q      <= ready_d;
         valid_q      <= valid_d;
         data_q       <= data_d;
         index_q      <= index_d;
         last_q       <= last_d;
         rd_en_q      <= rd_en_d;
      end
   end

   assign c0_ring_ready = ready_q[0];
   assign c1_ring_ready = ready_q[1];
   assign c0_rsp_valid  = valid_q[0];
   assign c1_rsp_valid  = valid_q[1];
   assign rsp_data      = data_q;
   assign rsp_index     = index_q;
   assign rsp_last      = last_q;
   assign mem_rd_en     = rd_en_q;
   assign mem_addr      = mem_addr_q;
endmodule
